// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, address field bounds and merge FSM states.
package noc_pkg;

    localparam int NOC_W   = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        SEND_W = 2'd1,
        SEND_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arbiter_merge2_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? prio : req[1];

endmodule

// File: rtl/arbiter_merge2.sv
// Merges two decoder output channels into one, emitting a winner token before each packet.
module arbiter_merge2
    import noc_pkg::*;
#(
    parameter int W  = NOC_W,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          _RESET,
    input  logic [W-1:0]  In0_data,
    input  logic          In0_valid,
    output logic          In0_ready,
    input  logic [W-1:0]  In1_data,
    input  logic          In1_valid,
    output logic          In1_ready,
    output logic [W-1:0]  Out_data,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic          Wn_data,
    output logic          Wn_valid,
    input  logic          Wn_ready,
    output logic [CW-1:0] Cnt0,
    output logic [CW-1:0] Cnt1
);

    arb_state_e    state_q;
    logic          prio_q;
    logic          win_q;
    logic [W-1:0]  data_q;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;

    logic gnt_valid;
    logic gnt_idx;
    logic accept;

    rr_arb2 u_rr_arb2 (
        .req       ({In1_valid, In0_valid}),
        .prio      (prio_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Handshake outputs are gated by reset so nothing is offered or accepted while it is held.
    assign accept    = _RESET && (state_q == ARB) && gnt_valid;
    assign In0_ready = accept && !gnt_idx;
    assign In1_ready = accept && gnt_idx;
    assign Wn_valid  = _RESET && (state_q == SEND_W);
    assign Wn_data   = win_q;
    assign Out_valid = _RESET && (state_q == SEND_D);
    assign Out_data  = data_q;
    assign Cnt0      = cnt0_q;
    assign Cnt1      = cnt1_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= ARB;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            data_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (accept) begin
                        data_q  <= gnt_idx ? In1_data : In0_data;
                        win_q   <= gnt_idx;
                        state_q <= SEND_W;
                    end
                end
                SEND_W: begin
                    if (Wn_ready) begin
                        state_q <= SEND_D;
                    end
                end
                SEND_D: begin
                    // Completion hands priority to the other input and credits the winner.
                    if (Out_ready) begin
                        state_q <= ARB;
                        prio_q  <= ~win_q;
                        if (win_q) begin
                            cnt1_q <= cnt1_q + 1'b1;
                        end else begin
                            cnt0_q <= cnt0_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_merge2.sv
// Self-checking bench for arbiter_merge2: directed scenarios plus a randomized run against a transaction model.
module tb_arbiter_merge2;

    localparam int TW  = 9;
    // Narrow counters make the wrap point reachable in a short run.
    localparam int TCW = 8;
    localparam int CMOD = 1 << TCW;

    logic           CLK;
    logic           rst_n;
    logic [TW-1:0]  In0_data, In1_data, Out_data;
    logic           In0_valid, In0_ready, In1_valid, In1_ready;
    logic           Out_valid, Out_ready, Wn_data, Wn_valid, Wn_ready;
    logic [TCW-1:0] Cnt0, Cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    arbiter_merge2 #(.W(TW), .CW(TCW)) dut (
        .CLK       (CLK),
        ._RESET    (rst_n),
        .In0_data  (In0_data),
        .In0_valid (In0_valid),
        .In0_ready (In0_ready),
        .In1_data  (In1_data),
        .In1_valid (In1_valid),
        .In1_ready (In1_ready),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Wn_data   (Wn_data),
        .Wn_valid  (Wn_valid),
        .Wn_ready  (Wn_ready),
        .Cnt0      (Cnt0),
        .Cnt1      (Cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        In0_valid = 1'b0; In1_valid = 1'b0;
        In0_data  = '0;   In1_data  = '0;
        Wn_ready  = 1'b1; Out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        #2;
        rst_n = 1'b0;
        In0_valid = 1'b1; In1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++; if (In0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in0_ready got %b exp 0", In0_ready); end
            n_tests++; if (In1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in1_ready got %b exp 0", In1_ready); end
            n_tests++; if (Wn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wn_valid got %b exp 0", Wn_valid); end
            n_tests++; if (Out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", Out_valid); end
            n_tests++; if (Cnt0 !== '0 || Cnt1 !== '0) begin n_fail++; $display("FAIL reset_cnt got %0h/%0h exp 0/0", Cnt0, Cnt1); end
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        In0_valid = 1'b1; In0_data = 9'h1A3;
        #1;
        n_tests++; if (In0_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept got %b exp 1", In0_ready); end
        tick();
        In0_valid = 1'b0;
        n_tests++; if (Wn_valid !== 1'b1 || Wn_data !== 1'b0) begin n_fail++; $display("FAIL single_wn got v=%b d=%b exp v=1 d=0", Wn_valid, Wn_data); end
        n_tests++; if (Out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_early got %b exp 0", Out_valid); end
        tick();
        n_tests++; if (Out_valid !== 1'b1 || Out_data !== 9'h1A3) begin n_fail++; $display("FAIL single_out got v=%b d=%h exp v=1 d=1a3", Out_valid, Out_data); end
        tick();
        n_tests++; if (Out_valid !== 1'b0 || Cnt0 !== 8'd1) begin n_fail++; $display("FAIL single_done got v=%b cnt0=%0d exp v=0 cnt0=1", Out_valid, Cnt0); end
    endtask

    task automatic test_contention();
        logic           exp_w;
        logic [TW-1:0]  exp_d;
        do_reset();
        In0_valid = 1'b1; In0_data = 9'h100;
        In1_valid = 1'b1; In1_data = 9'h0FF;
        for (int k = 0; k < 4; k++) begin
            exp_w = (k % 2 == 1);
            exp_d = exp_w ? 9'h0FF : 9'h100;
            #1;
            n_tests++; if (In0_ready !== !exp_w || In1_ready !== exp_w) begin n_fail++; $display("FAIL cont_grant%0d got r0=%b r1=%b exp winner %b", k, In0_ready, In1_ready, exp_w); end
            tick();
            n_tests++; if (Wn_valid !== 1'b1 || Wn_data !== exp_w) begin n_fail++; $display("FAIL cont_wn%0d got v=%b d=%b exp d=%b", k, Wn_valid, Wn_data, exp_w); end
            tick();
            n_tests++; if (Out_valid !== 1'b1 || Out_data !== exp_d) begin n_fail++; $display("FAIL cont_out%0d got v=%b d=%h exp %h", k, Out_valid, Out_data, exp_d); end
            tick();
        end
        n_tests++; if (Cnt0 !== 8'd2 || Cnt1 !== 8'd2) begin n_fail++; $display("FAIL cont_cnt got %0d/%0d exp 2/2", Cnt0, Cnt1); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        Wn_ready = 1'b0; Out_ready = 1'b0;
        In1_valid = 1'b1; In1_data = 9'h0A5;
        tick();
        In1_valid = 1'b0;
        In0_valid = 1'b1; In0_data = 9'h055;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (Wn_valid !== 1'b1 || Wn_data !== 1'b1 || Out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_wn_hold%0d got v=%b d=%b ov=%b exp 1/1/0", i, Wn_valid, Wn_data, Out_valid); end
            n_tests++; if (In0_ready !== 1'b0 || In1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_wn_inrdy%0d got %b%b exp 00", i, In0_ready, In1_ready); end
            tick();
        end
        Wn_ready = 1'b1;
        tick();
        Wn_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (Out_valid !== 1'b1 || Out_data !== 9'h0A5 || Wn_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_hold%0d got v=%b d=%h wv=%b exp 1/0a5/0", i, Out_valid, Out_data, Wn_valid); end
            n_tests++; if (In0_ready !== 1'b0 || In1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_out_inrdy%0d got %b%b exp 00", i, In0_ready, In1_ready); end
            tick();
        end
        Out_ready = 1'b1;
        tick();
        n_tests++; if (Cnt1 !== 8'd1 || In0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done got cnt1=%0d r0=%b exp 1/1", Cnt1, In0_ready); end
        tick();
        In0_valid = 1'b0; Wn_ready = 1'b1;
        tick();
        n_tests++; if (Out_data !== 9'h055) begin n_fail++; $display("FAIL bp_second_data got %h exp 055", Out_data); end
        tick();
        n_tests++; if (Cnt0 !== 8'd1) begin n_fail++; $display("FAIL bp_second_cnt got %0d exp 1", Cnt0); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_tests++; if ({In0_ready, In1_ready, Wn_valid, Out_valid} !== 4'b0) begin n_fail++; $display("FAIL idle%0d got %b exp 0000", i, {In0_ready, In1_ready, Wn_valid, Out_valid}); end
            tick();
        end
        In1_valid = 1'b1; In1_data = 9'h033;
        #1;
        n_tests++; if (In1_ready !== 1'b1) begin n_fail++; $display("FAIL idle_still_arb got %b exp 1", In1_ready); end
        tick();
        In1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        Out_ready = 1'b0;
        In0_valid = 1'b1; In0_data = 9'h1F0;
        tick();
        In0_valid = 1'b0;
        tick();
        n_tests++; if (Out_valid !== 1'b1 || Out_data !== 9'h1F0) begin n_fail++; $display("FAIL rmid_send_d got v=%b d=%h exp 1/1f0", Out_valid, Out_data); end
        #2;
        rst_n = 1'b0;
        In1_valid = 1'b1;
        #1;
        n_tests++; if (Out_valid !== 1'b0 || Wn_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async got ov=%b wv=%b exp 0/0", Out_valid, Wn_valid); end
        n_tests++; if (In1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_rdy got %b exp 0", In1_ready); end
        #2;
        rst_n = 1'b1;
        In1_valid = 1'b0; Out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (Out_valid !== 1'b0 || Wn_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost%0d got ov=%b wv=%b exp 0/0", i, Out_valid, Wn_valid); end
        end
        n_tests++; if (Cnt0 !== '0 || Cnt1 !== '0) begin n_fail++; $display("FAIL rmid_cnt got %0d/%0d exp 0/0", Cnt0, Cnt1); end
        In0_valid = 1'b1; In1_valid = 1'b1;
        #1;
        n_tests++; if (In0_ready !== 1'b1 || In1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_prio got r0=%b r1=%b exp 1/0", In0_ready, In1_ready); end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        In1_valid = 1'b1; In1_data = 9'h1C7;
        for (int i = 0; i < (CMOD - 1) * 3; i++) tick();
        n_tests++; if (Cnt1 !== 8'hFF) begin n_fail++; $display("FAIL wrap_max got %0h exp ff", Cnt1); end
        for (int i = 0; i < 3; i++) tick();
        n_tests++; if (Cnt1 !== 8'h00 || Cnt0 !== 8'h00) begin n_fail++; $display("FAIL wrap_zero got cnt1=%0h cnt0=%0h exp 0/0", Cnt1, Cnt0); end
        In1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        // Transaction model: at most one packet in flight, token then data, priority flips to the loser.
        bit            busy, sent_w, win, prio;
        logic [TW-1:0] pkt;
        int            c0, c1;
        logic          e_r0, e_r1;
        do_reset();
        busy = 0; sent_w = 0; win = 0; prio = 0; pkt = '0; c0 = 0; c1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!In0_valid) begin In0_valid = 1'($urandom_range(0, 1)); In0_data = 9'($urandom); end
            if (!In1_valid) begin In1_valid = 1'($urandom_range(0, 1)); In1_data = 9'($urandom); end
            Wn_ready  = ($urandom_range(0, 9) < 7);
            Out_ready = ($urandom_range(0, 9) < 7);
            #1;
            e_r0 = !busy && In0_valid && (!In1_valid || prio == 0);
            e_r1 = !busy && In1_valid && (!In0_valid || prio == 1);
            n_tests++; if (In0_ready !== e_r0 || In1_ready !== e_r1) begin n_fail++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", cyc, In0_ready, In1_ready, e_r0, e_r1); end
            n_tests++; if (Wn_valid !== (busy && !sent_w) || Out_valid !== (busy && sent_w)) begin n_fail++; $display("FAIL rnd_valid c%0d got wv=%b ov=%b exp %b/%b", cyc, Wn_valid, Out_valid, busy && !sent_w, busy && sent_w); end
            if (busy && !sent_w) begin
                n_tests++; if (Wn_data !== win) begin n_fail++; $display("FAIL rnd_wn c%0d got %b exp %b", cyc, Wn_data, win); end
            end
            if (busy && sent_w) begin
                n_tests++; if (Out_data !== pkt) begin n_fail++; $display("FAIL rnd_out c%0d got %h exp %h", cyc, Out_data, pkt); end
            end
            n_tests++; if (Cnt0 !== TCW'(c0) || Cnt1 !== TCW'(c1)) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", cyc, Cnt0, Cnt1, c0, c1); end
            if (e_r0) begin busy = 1; sent_w = 0; win = 0; pkt = In0_data; end
            else if (e_r1) begin busy = 1; sent_w = 0; win = 1; pkt = In1_data; end
            else if (busy && !sent_w && Wn_ready) sent_w = 1;
            else if (busy && sent_w && Out_ready) begin
                busy = 0; prio = !win;
                if (win) c1 = (c1 + 1) % CMOD; else c0 = (c0 + 1) % CMOD;
            end
            tick();
            if (e_r0) In0_valid = 1'b0;
            if (e_r1) In1_valid = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_idle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
